// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store SRAM controller: access-size codes,
// FSM state encoding and the byte-enable / write-lane helpers.
package lsu_pkg;

    // Access size codes as carried on req_size (3 is reserved)
    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;

    // Controller FSM states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DATA  = 2'd2,
        ST_RESP  = 2'd3
    } state_e;

    // Byte enables for an access; halves use off[1] only, so a misaligned
    // half or word is forced onto its aligned lanes. Reserved size acts as word.
    function automatic logic [3:0] byte_en(input logic [1:0] size, input logic [1:0] off);
        logic [3:0] be;
        case (size)
            SZ_B:    be = 4'b0001 << off;
            SZ_H:    be = 4'b0011 << {off[1], 1'b0};
            default: be = 4'hF;
        endcase
        return be;
    endfunction

    // Replicate right-aligned store data across every lane it could occupy
    function automatic logic [31:0] wdata_rep(input logic [1:0] size, input logic [31:0] wdata);
        logic [31:0] d;
        case (size)
            SZ_B:    d = {4{wdata[7:0]}};
            SZ_H:    d = {2{wdata[15:0]}};
            default: d = wdata;
        endcase
        return d;
    endfunction

    // Alignment fault: odd half, unaligned word, or reserved size
    function automatic logic misaligned(input logic [1:0] size, input logic [1:0] off);
        logic f;
        case (size)
            SZ_B:    f = 1'b0;
            SZ_H:    f = off[0];
            SZ_W:    f = (off != 2'b00);
            default: f = 1'b1;
        endcase
        return f;
    endfunction

endpackage

// File: rtl/lsu_sram_ctrl_if.sv
// Bundle of the CPU request/response handshake and the SRAM port.
// Handshakes: a transfer happens on a rising edge where valid and ready
// are both high; valid, once raised, holds its payload until that edge.
// slave  = the controller's view; master = the CPU + SRAM environment.
// dbg_state exposes the controller FSM state for observation.
interface lsu_sram_ctrl_if #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 32
);
    import lsu_pkg::*;

    logic                  req_valid;
    logic                  req_ready;
    logic                  req_we;
    logic [1:0]            req_size;
    logic                  req_unsigned;
    logic [31:0]           req_addr;
    logic [DATA_WIDTH-1:0] req_wdata;

    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [DATA_WIDTH-1:0] rsp_rdata;
    logic                  rsp_err;

    logic                  mem_cs;
    logic                  mem_we;
    logic [3:0]            mem_be;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_din;
    logic [DATA_WIDTH-1:0] mem_dout;

    state_e                dbg_state;

    modport slave (
        input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
        output req_ready,
        output rsp_valid, rsp_rdata, rsp_err,
        input  rsp_ready,
        output mem_cs, mem_we, mem_be, mem_addr, mem_din,
        input  mem_dout,
        output dbg_state
    );

    modport master (
        output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
        input  req_ready,
        input  rsp_valid, rsp_rdata, rsp_err,
        output rsp_ready,
        input  mem_cs, mem_we, mem_be, mem_addr, mem_din,
        output mem_dout,
        input  dbg_state
    );

endinterface

// File: rtl/lsu_load_align.sv
// Selects the addressed lane(s) of an SRAM read word and sign- or
// zero-extends them to 32 bits. Purely combinational.
module lsu_load_align
    import lsu_pkg::*;
(
    input  logic [31:0] dout,
    input  logic [1:0]  off,
    input  logic [1:0]  size,
    input  logic        is_unsigned,
    output logic [31:0] result
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;

    // Lane select then extend; word and reserved size pass through
    always_comb begin
        byte_v = dout[{off, 3'b000} +: 8];
        half_v = off[1] ? dout[31:16] : dout[15:0];
        case (size)
            SZ_B:    result = is_unsigned ? {24'b0, byte_v} : {{24{byte_v[7]}}, byte_v};
            SZ_H:    result = is_unsigned ? {16'b0, half_v} : {{16{half_v[15]}}, half_v};
            default: result = dout;
        endcase
    end

endmodule

// File: rtl/lsu_sram_ctrl.sv
// Load/store controller between the core MEM stage and a single-port
// synchronous SRAM (read data registered, valid one cycle after cs).
// One request in flight: IDLE -> ISSUE -> [DATA] -> RESP -> IDLE.
// Optional: define MISALIGN_TRAP_EN to answer misaligned or reserved-size
// requests with rsp_err=1 and no SRAM access; otherwise low address bits
// are ignored and rsp_err is 0.
module lsu_sram_ctrl
    import lsu_pkg::*;
#(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 32
) (
    input  logic           clk,
    input  logic           rst,
    lsu_sram_ctrl_if.slave bus
);

    state_e                state_q, state_d;
    logic                  we_q, we_d;
    logic [1:0]            size_q, size_d;
    logic                  uns_q, uns_d;
    logic [1:0]            off_q, off_d;
    logic [ADDR_WIDTH-1:0] waddr_q, waddr_d;
    logic [31:0]           wdata_q, wdata_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic [31:0]           load_data;
    logic                  fault;
    logic                  issue;
    logic                  unused_addr_bits;

`ifdef MISALIGN_TRAP_EN
    logic                  err_q, err_d;
`endif

    // Only the word-address window is decoded; everything above wraps
    assign unused_addr_bits = ^bus.req_addr[31:ADDR_WIDTH+2];

`ifdef MISALIGN_TRAP_EN
    assign fault = misaligned(bus.req_size, bus.req_addr[1:0]);
`else
    assign fault = 1'b0;
`endif

    lsu_load_align u_load_align (
        .dout        (bus.mem_dout),
        .off         (off_q),
        .size        (size_q),
        .is_unsigned (uns_q),
        .result      (load_data)
    );

    // State and capture registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            we_q    <= 1'b0;
            size_q  <= 2'b00;
            uns_q   <= 1'b0;
            off_q   <= 2'b00;
            waddr_q <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            size_q  <= size_d;
            uns_q   <= uns_d;
            off_q   <= off_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end

`ifdef MISALIGN_TRAP_EN
    // Fault flag for the pending response
    always_ff @(posedge clk or posedge rst) begin
        if (rst) err_q <= 1'b0;
        else     err_q <= err_d;
    end
`endif

    // Next state: capture in IDLE, sequence the SRAM access, hold the response
    always_comb begin
        state_d = state_q;
        we_d    = we_q;
        size_d  = size_q;
        uns_d   = uns_q;
        off_d   = off_q;
        waddr_d = waddr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
`ifdef MISALIGN_TRAP_EN
        err_d   = err_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (bus.req_valid) begin
                    we_d    = bus.req_we;
                    size_d  = bus.req_size;
                    uns_d   = bus.req_unsigned;
                    off_d   = bus.req_addr[1:0];
                    waddr_d = bus.req_addr[ADDR_WIDTH+1:2];
                    wdata_d = bus.req_wdata;
                    rdata_d = '0;
`ifdef MISALIGN_TRAP_EN
                    err_d   = fault;
`endif
                    state_d = fault ? ST_RESP : ST_ISSUE;
                end
            end
            ST_ISSUE: state_d = we_q ? ST_RESP : ST_DATA;
            ST_DATA: begin
                rdata_d = load_data;
                state_d = ST_RESP;
            end
            ST_RESP: begin
                if (bus.rsp_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Outputs decoded from state and capture registers only
    always_comb begin
        issue          = (state_q == ST_ISSUE);
        bus.req_ready  = (state_q == ST_IDLE);
        bus.rsp_valid  = (state_q == ST_RESP);
        bus.rsp_rdata  = rdata_q;
`ifdef MISALIGN_TRAP_EN
        bus.rsp_err    = err_q;
`else
        bus.rsp_err    = 1'b0;
`endif
        bus.mem_cs     = issue;
        bus.mem_we     = issue & we_q;
        bus.mem_be     = issue ? byte_en(size_q, off_q) : 4'b0000;
        bus.mem_addr   = issue ? waddr_q : '0;
        bus.mem_din    = issue ? wdata_rep(size_q, wdata_q) : '0;
        bus.dbg_state  = state_q;
    end

endmodule

// File: tb/tb_lsu_sram_ctrl.sv
// Directed and random bench for lsu_sram_ctrl with a behavioural SRAM and
// a byte-array reference memory.
module tb_lsu_sram_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;

    lsu_sram_ctrl_if #(.ADDR_WIDTH(10), .DATA_WIDTH(32)) bus ();

    lsu_sram_ctrl #(.ADDR_WIDTH(10), .DATA_WIDTH(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // SRAM model: synchronous, registered read data
    logic [31:0] sram [1024];
    logic [31:0] sram_dout = 32'h0;
    assign bus.mem_dout = sram_dout;

    always @(posedge clk) begin
        if (bus.mem_cs) begin
            if (bus.mem_we) begin
                for (int i = 0; i < 4; i++)
                    if (bus.mem_be[i]) sram[bus.mem_addr][i*8 +: 8] <= bus.mem_din[i*8 +: 8];
            end
            sram_dout <= sram[bus.mem_addr];
        end
    end

    // Reference: byte-addressed 4 KB memory
    logic [7:0] ref_mem [4096];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic bit ref_fault(input int size, input int addr);
`ifdef MISALIGN_TRAP_EN
        if (size == 3) return 1'b1;
        if (size == 1 && (addr % 2) != 0) return 1'b1;
        if (size == 2 && (addr % 4) != 0) return 1'b1;
`endif
        return 1'b0;
    endfunction

    function automatic logic [31:0] ref_load(input int size, input bit uns, input int addr);
        int a;
        logic [31:0] v;
        a = addr % 4096;
        if (size == 0) begin
            v = 32'(ref_mem[a]);
            if (!uns && v >= 128) v = v - 32'd256;
        end else if (size == 1) begin
            a = a - (a % 4) + ((a % 4) / 2) * 2;
            v = 32'(ref_mem[a]) + 32'(ref_mem[a+1]) * 256;
            if (!uns && v >= 32768) v = v - 32'd65536;
        end else begin
            a = a - (a % 4);
            v = 32'(ref_mem[a]) + 32'(ref_mem[a+1]) * 256 + 32'(ref_mem[a+2]) * 65536
                + 32'(ref_mem[a+3]) * 16777216;
        end
        return v;
    endfunction

    task automatic ref_store(input int size, input int addr, input logic [31:0] wd);
        int a;
        a = addr % 4096;
        if (size == 0) begin
            ref_mem[a] = wd[7:0];
        end else if (size == 1) begin
            a = a - (a % 4) + ((a % 4) / 2) * 2;
            ref_mem[a]   = wd[7:0];
            ref_mem[a+1] = wd[15:8];
        end else begin
            a = a - (a % 4);
            for (int i = 0; i < 4; i++) ref_mem[a+i] = wd[i*8 +: 8];
        end
    endtask

    // One full transaction; hold = cycles rsp_ready stays low once rsp_valid is up
    task automatic do_req(input bit we, input int size, input bit uns, input int addr,
                          input logic [31:0] wd, input int hold);
        bit          flt;
        int          cyc;
        int          cs_seen;
        int          exp_lat;
        logic [3:0]  exp_be;
        logic [31:0] exp_din;
        logic [31:0] exp_rd;
        logic [31:0] held_rd;
        logic        held_err;
        int          off;

        off = addr % 4;
        flt = ref_fault(size, addr);
        if (size == 0)      exp_be = 4'(1 << off);
        else if (size == 1) exp_be = (off >= 2) ? 4'b1100 : 4'b0011;
        else                exp_be = 4'hF;
        if (size == 0)      exp_din = {4{wd[7:0]}};
        else if (size == 1) exp_din = {2{wd[15:0]}};
        else                exp_din = wd;
        exp_rd  = (flt || we) ? 32'h0 : ref_load(size, uns, addr);
        exp_lat = flt ? 1 : (we ? 2 : 3);

        check("req_ready_idle", 32'(bus.req_ready), 32'd1);
        bus.req_valid    = 1'b1;
        bus.req_we       = we;
        bus.req_size     = 2'(size);
        bus.req_unsigned = uns;
        bus.req_addr     = addr;
        bus.req_wdata    = wd;
        @(posedge clk);
        #1;
        bus.req_valid    = 1'b0;
        bus.req_we       = 1'($urandom);
        bus.req_size     = 2'($urandom);
        bus.req_unsigned = 1'($urandom);
        bus.req_addr     = $urandom;
        bus.req_wdata    = $urandom;

        if (!flt) begin
            check("c1_mem_cs",   32'(bus.mem_cs),   32'd1);
            check("c1_mem_we",   32'(bus.mem_we),   32'(we));
            check("c1_mem_be",   32'(bus.mem_be),   32'(exp_be));
            check("c1_mem_addr", 32'(bus.mem_addr), 32'((addr / 4) % 1024));
            if (we) check("c1_mem_din", bus.mem_din, exp_din);
        end

        cyc = 1;
        cs_seen = 0;
        while (!bus.rsp_valid && cyc < 20) begin
            cs_seen += int'(bus.mem_cs);
            @(posedge clk);
            #1;
            cyc++;
        end
        cs_seen += int'(bus.mem_cs);
        check("rsp_valid_seen", 32'(bus.rsp_valid), 32'd1);
        check("rsp_latency",    32'(cyc),           32'(exp_lat));
        check("cs_pulses",      32'(cs_seen),       flt ? 32'd0 : 32'd1);
        check("rsp_rdata",      bus.rsp_rdata,      exp_rd);
        check("rsp_err",        32'(bus.rsp_err),   32'(flt));

        held_rd  = bus.rsp_rdata;
        held_err = bus.rsp_err;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            check("hold_valid", 32'(bus.rsp_valid), 32'd1);
            check("hold_rdata", bus.rsp_rdata,      held_rd);
            check("hold_err",   32'(bus.rsp_err),   32'(held_err));
            check("hold_ready", 32'(bus.req_ready), 32'd0);
            check("hold_cs",    32'(bus.mem_cs),    32'd0);
        end

        bus.rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.rsp_ready = 1'b0;
        check("post_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("post_req_ready", 32'(bus.req_ready), 32'd1);

        if (we && !flt) ref_store(size, addr, wd);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_req_ready"}, 32'(bus.req_ready), 32'd1);
        check({tag, "_rsp_valid"}, 32'(bus.rsp_valid), 32'd0);
        check({tag, "_rsp_rdata"}, bus.rsp_rdata,      32'd0);
        check({tag, "_rsp_err"},   32'(bus.rsp_err),   32'd0);
        check({tag, "_mem_cs"},    32'(bus.mem_cs),    32'd0);
        check({tag, "_mem_we"},    32'(bus.mem_we),    32'd0);
        check({tag, "_mem_be"},    32'(bus.mem_be),    32'd0);
        check({tag, "_mem_addr"},  32'(bus.mem_addr),  32'd0);
        check({tag, "_mem_din"},   bus.mem_din,        32'd0);
    endtask

    initial begin
        logic [31:0] v;

        bus.req_valid    = 1'b0;
        bus.req_we       = 1'b0;
        bus.req_size     = 2'd0;
        bus.req_unsigned = 1'b0;
        bus.req_addr     = 32'h0;
        bus.req_wdata    = 32'h0;
        bus.rsp_ready    = 1'b0;
        for (int w = 0; w < 1024; w++) begin
            v = $urandom;
            sram[w] <= v;
            for (int b = 0; b < 4; b++) ref_mem[w*4+b] = v[b*8 +: 8];
        end

        // Reset: hold a valid request during reset; nothing may be accepted
        bus.req_valid = 1'b1;
        bus.req_we    = 1'b1;
        bus.req_size  = 2'd2;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        bus.req_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check_reset_outputs("idle_after_reset");

        // Word store/load
        do_req(1'b1, 2, 1'b0, 32'h010, 32'hDEADBEEF, 0);
        do_req(1'b0, 2, 1'b0, 32'h010, 32'h0, 0);
        check("word_roundtrip", ref_load(2, 1'b0, 32'h010), 32'hDEADBEEF);

        // Byte store, signed and unsigned reload
        do_req(1'b1, 0, 1'b0, 32'h013, 32'h00000080, 0);
        do_req(1'b0, 0, 1'b0, 32'h013, 32'h0, 0);
        do_req(1'b0, 0, 1'b1, 32'h013, 32'h0, 0);

        // Half store, signed reload, other half of the word untouched
        do_req(1'b1, 1, 1'b0, 32'h022, 32'h00008001, 0);
        do_req(1'b0, 1, 1'b0, 32'h022, 32'h0, 0);
        do_req(1'b0, 2, 1'b0, 32'h020, 32'h0, 0);

        // Backpressure on a load response
        do_req(1'b0, 2, 1'b0, 32'h010, 32'h0, 5);

        // Upper address bits wrap
        do_req(1'b1, 2, 1'b0, 32'h1004, 32'h12345678, 0);
        do_req(1'b0, 2, 1'b0, 32'h004, 32'h0, 0);

        // Misaligned word: fault with the trap, aligned read without it
        do_req(1'b0, 2, 1'b0, 32'h002, 32'h0, 0);
        do_req(1'b1, 3, 1'b0, 32'h008, 32'hCAFEF00D, 1);

        // Reset asserted between edges while a load sits in DATA
        bus.req_valid    = 1'b1;
        bus.req_we       = 1'b0;
        bus.req_size     = 2'd2;
        bus.req_unsigned = 1'b0;
        bus.req_addr     = 32'h010;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check_reset_outputs("mid_data_reset");
        @(negedge clk);
        rst = 1'b0;
        #1;
        do_req(1'b0, 2, 1'b0, 32'h010, 32'h0, 0);

        // Random traffic
        for (int n = 0; n < 60; n++) begin
            do_req(1'($urandom_range(0, 1)), $urandom_range(0, 3), 1'($urandom_range(0, 1)),
                   $urandom_range(0, 63) + 4096 * $urandom_range(0, 3), $urandom,
                   $urandom_range(0, 2));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
